gate_bist_checker: RTL
======================

Name: gate_bist_checker

Overview:
- Synthesizable self-test engine for the two-input basic-gate block (inputs a, b; outputs y1..y7).
- Sweeps all four input combinations, waits a settle interval, samples the seven gate outputs and compares them against a built-in golden model.
- Reports pass/fail, an error count and first-failure details.
- Sits beside the gate block as its on-chip stimulus driver and response checker, replacing manual waveform inspection.

Parameters:
- SETTLE_CYCLES, 2, cycles the vector is held before sampling (legal range 1..15).
- PASSES, 1, number of full 4-vector sweeps per run (legal range 1..255).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request, sampled in IDLE and DONE only.
- a_o  out  1  stimulus to gate block input a.
- b_o  out  1  stimulus to gate block input b.
- y_i  in  7  gate block outputs; bit0=y1 ... bit6=y7.
- busy  out  1  high while a sweep is in progress.
- done  out  1  level; high from end of run until next accepted start.
- pass  out  1  valid when done=1; high iff err_count==0.
- err_count  out  CNT_W  mismatching vectors counted; saturates at all-ones.
- first_fail_vec  out  2  {a,b} of first mismatching vector.
- first_fail_mask  out  7  XOR of expected and y_i at first mismatch.

Behaviour:
- Reset is asynchronous and active-low on rst_n. While rst_n=0, every output is 0 and the FSM is in IDLE. Reset mid-sweep aborts immediately; no partial results are retained.
- Golden model, fixed:
  - y1 = a&b
  - y2 = a|b
  - y3 = ~a
  - y4 = ~(a&b)
  - y5 = ~(a|b)
  - y6 = a^b
  - y7 = ~(a^b)
- Vector order per pass: {a,b} = 00, 01, 10, 11. a_o/b_o are registered.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
  - IDLE: start=1 → SETTLE. On that edge: vec=0, pass_idx=0, settle_cnt=0, err_count/first_fail_* cleared, busy=1, a_o/b_o=vector 0.
  - SETTLE: settle_cnt increments each cycle. When settle_cnt==SETTLE_CYCLES-1 → SAMPLE.
  - SAMPLE (one cycle):
    - Compare y_i against the golden model for the current {a_o,b_o}.
    - On mismatch, increment err_count, saturating.
    - If this is the first mismatch of the run, capture first_fail_vec and first_fail_mask.
    - If vec<3: vec+1, drive the next vector, → SETTLE.
    - If vec==3 and pass_idx<PASSES-1: vec=0, pass_idx+1, → SETTLE.
    - Otherwise → DONE.
  - DONE: busy=0, done=1, pass=(err_count==0). Results hold. start=1 → same action as start in IDLE (clears done/pass/results, begins a new run).
- start while busy is ignored and has no effect.
- Latency:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - done rises 4·(SETTLE_CYCLES+1)·PASSES cycles after the start-accepting edge. With defaults that is 12.
- first_fail_* are 0 if no mismatch occurs. Only the first mismatch across all passes is recorded.
- err_count saturates at 2^CNT_W−1 and never wraps.
- pass and first_fail_* are meaningful only when done=1. They read 0 during busy except for first_fail_*, which updates on capture.
- X on y_i is not handled specially; behaviour on X is undefined.

Decomposition:
- Shared package gate_bist_pkg holds:
  - state enum {IDLE, SETTLE, SAMPLE, DONE};
  - bit-index constants Y_AND=0, Y_OR=1, Y_NOTA=2, Y_NAND=3, Y_NOR=4, Y_XOR=5, Y_XNOR=6;
  - function gate_expect(a,b) returning the 7-bit golden vector.
- One natural sub-module: gate_bist_cmp, purely combinational. It takes a, b and y_i and produces mismatch_mask[6:0] and any_mismatch. The FSM/counters stay in the top.

Test Plan:
- Defaults, healthy gate block connected: pulse start → busy for 12 cycles, then done=1, pass=1, err_count=0, first_fail_vec=0, first_fail_mask=0.
- y6 stuck at 0 → done after 12 cycles, pass=0, err_count=2, first_fail_vec=2'b01, first_fail_mask=7'b0100000.
- CNT_W=2, PASSES=2, all y_i inverted → 8 mismatches, err_count=2'b11 (saturated), first_fail_vec=2'b00, first_fail_mask=7'h7F, done after 24 cycles.
- start re-pulsed at cycle 5 of a run → ignored; done still at cycle 12 with unchanged results.
- rst_n low at cycle 7 of a run → all outputs 0 immediately (asynchronously); after release, a new start gives a full clean 12-cycle run.
- From DONE with a failing result, fix the fault and pulse start → done/pass/err_count cleared on that edge; new run ends with pass=1.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared types, output bit positions and golden truth model for the gate BIST.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } bist_state_t;

    // Bit positions of the gate outputs inside the 7-bit response word (y1..y7).
    localparam int Y_AND  = 0;
    localparam int Y_OR   = 1;
    localparam int Y_NOTA = 2;
    localparam int Y_NAND = 3;
    localparam int Y_NOR  = 4;
    localparam int Y_XOR  = 5;
    localparam int Y_XNOR = 6;

    // Response a healthy gate block must produce for the given inputs.
    function automatic logic [6:0] gate_expect(input logic a, input logic b);
        logic [6:0] y;
        y         = '0;
        y[Y_AND]  = a & b;
        y[Y_OR]   = a | b;
        y[Y_NOTA] = ~a;
        y[Y_NAND] = ~(a & b);
        y[Y_NOR]  = ~(a | b);
        y[Y_XOR]  = a ^ b;
        y[Y_XNOR] = ~(a ^ b);
        return y;
    endfunction

endpackage

// File: rtl/gate_bist_cmp.sv
// Combinational response checker: compares the gate outputs with the golden model.
module gate_bist_cmp
    import gate_bist_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [6:0] y_i,
    output logic [6:0] mismatch_mask,
    output logic       any_mismatch
);

    // Flag every output bit that disagrees with the expected truth table.
    always_comb begin
        mismatch_mask = gate_expect(a, b) ^ y_i;
        any_mismatch  = |mismatch_mask;
    end

endmodule

// File: rtl/gate_bist_checker.sv
// Self-test engine for the two-input gate block: sweeps all input vectors,
// samples the seven outputs after a settle interval and accumulates results.
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    input  logic [6:0]       y_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       first_fail_vec,
    output logic [6:0]       first_fail_mask
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       PASS_LAST   = 8'(PASSES - 1);
    localparam logic [CNT_W-1:0] ERR_MAX     = '1;

    bist_state_t state;
    bist_state_t next_state;
    logic [3:0]  settle_cnt;
    logic [7:0]  pass_idx;
    logic [1:0]  vec;
    logic        load_run;
    logic        more_vectors;
    logic [6:0]  mismatch_mask;
    logic        any_mismatch;

    // The driven stimulus itself is the vector index, so no separate copy is kept.
    assign vec          = {a_o, b_o};
    assign more_vectors = (vec != 2'd3) || (pass_idx != PASS_LAST);

    gate_bist_cmp u_cmp (
        .a             (a_o),
        .b             (b_o),
        .y_i           (y_i),
        .mismatch_mask (mismatch_mask),
        .any_mismatch  (any_mismatch)
    );

    // State register; reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and status outputs derived from the current state.
    always_comb begin
        next_state = state;
        load_run   = 1'b0;
        busy       = (state == SETTLE) || (state == SAMPLE);
        done       = (state == DONE);
        pass       = (state == DONE) && (err_count == '0);
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = SETTLE;
                    load_run   = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    next_state = SAMPLE;
                end
            end
            SAMPLE: begin
                next_state = more_vectors ? SETTLE : DONE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Stimulus, counters and result capture; a new run clears all prior results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt      <= '0;
            pass_idx        <= '0;
            a_o             <= 1'b0;
            b_o             <= 1'b0;
            err_count       <= '0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
        end else if (load_run) begin
            settle_cnt      <= '0;
            pass_idx        <= '0;
            a_o             <= 1'b0;
            b_o             <= 1'b0;
            err_count       <= '0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
        end else begin
            case (state)
                SETTLE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
                SAMPLE: begin
                    if (any_mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + 1'b1;
                        end
                        if (err_count == '0) begin
                            first_fail_vec  <= vec;
                            first_fail_mask <= mismatch_mask;
                        end
                    end
                    if (more_vectors) begin
                        settle_cnt <= '0;
                        {a_o, b_o} <= vec + 2'd1;
                        if (vec == 2'd3) begin
                            pass_idx <= pass_idx + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
